// File: rtl/scan_mux.sv
// scan_mux: registered N-channel time-multiplexing selector.
// Auto mode scans enabled channels at a fixed dwell; manual mode is a registered N:1 mux.
module scan_mux #(
  parameter int N_CH = 4,
  parameter int W    = 4,
  parameter int DIV  = 4,
  localparam int SELW = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [SELW-1:0]   sel_in,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH*W-1:0] data_in,
  output logic [W-1:0]      data_out,
  output logic [SELW-1:0]   ch_sel,
  output logic [N_CH-1:0]   ch_onehot,
  output logic              tick
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic [W-1:0]    data_q, data_d;
  logic [N_CH-1:0] onehot_q, onehot_d;
  logic            tick_q, tick_d;

  logic [SELW-1:0] adv_ch;
  logic [SELW:0]   cand;
  logic            found;
  logic [W-1:0]    word;
  logic            hit;

  // Next enabled channel after ch_q, searching ch+1 .. wrapping back to ch itself.
  always_comb begin
    adv_ch = ch_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = {1'b0, ch_q} + (SELW+1)'(k);
      if (cand >= (SELW+1)'(N_CH)) begin
        cand = cand - (SELW+1)'(N_CH);
      end
      if (!found && ch_en[cand[SELW-1:0]]) begin
        adv_ch = cand[SELW-1:0];
        found  = 1'b1;
      end
    end
  end

  // Prescaler, channel and tick next-state for auto/manual/frozen operation.
  always_comb begin
    pcnt_d = pcnt_q;
    ch_d   = ch_q;
    tick_d = 1'b0;
    if (en) begin
      if (mode) begin
        pcnt_d = '0;
        if ({1'b0, sel_in} < (SELW+1)'(N_CH)) begin
          ch_d = sel_in;
        end
      end else if (pcnt_q == PW'(DIV - 1)) begin
        pcnt_d = '0;
        tick_d = 1'b1;
        ch_d   = adv_ch;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  // Output word and strobe follow the next channel so they line up with ch_sel.
  always_comb begin
    word = '0;
    hit  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_d == SELW'(k)) begin
        word = data_in[k*W +: W];
        hit  = ch_en[k];
      end
    end
    data_d   = hit ? word : '0;
    onehot_d = hit ? (N_CH'(1) << ch_d) : '0;
  end

  // State and output registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q   <= '0;
      ch_q     <= '0;
      data_q   <= '0;
      onehot_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      ch_q     <= ch_d;
      data_q   <= data_d;
      onehot_q <= onehot_d;
      tick_q   <= tick_d;
    end
  end

  assign data_out  = data_q;
  assign ch_sel    = ch_q;
  assign ch_onehot = onehot_q;
  assign tick      = tick_q;

endmodule
